sram_arbiter: RTL and testbench

Three-port arbiter and cycle sequencer for the single external 8-bit asynchronous SRAM (21-bit address, active-low WE) shared by the CPU bus, the video fetch unit and the SD/DMA loader in the chipset clock domain. It grants one access at a time, drives the SRAM pins from registers, and returns read data or write completion to the granted requester over a req/ack handshake. Tri-state resolution of the SRAM data pins happens at the top level.

---
 rtl/sram_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Three-port arbiter and access sequencer for the shared external 8-bit
//   asynchronous SRAM. One access runs at a time. The SRAM pins are driven
//   from registers, and each access completes with a one-cycle ack to the
//   port that was granted.
//
//   Ports
//     clk_chipset, reset_n          : clock (rising edge), async active-low reset
//     cpu_req/we/addr/wdata         : CPU request (we=1 -> write)
//     cpu_rdata/cpu_ack             : CPU read data, completion pulse
//     vid_req/vid_addr              : video read-only request
//     vid_rdata/vid_ack             : video read data, completion pulse
//     dma_req/we/addr/wdata         : SD/DMA loader request
//     dma_rdata/dma_ack             : DMA read data, completion pulse
//     SRAM_ADDR                     : SRAM address
//     SRAM_DATA_O / SRAM_DATA_I     : write data to pins / read-back from pins
//     SRAM_DATA_OE                  : 1 = top level drives SRAM_DATA_O on pins
//     SRAM_WE_n                     : SRAM write enable, active low
module sram_arbiter #(
  parameter int AW       = 21,
  parameter int RD_WAIT  = 2,
  parameter int WE_WIDTH = 1
) (
  input  logic          clk_chipset,
  input  logic          reset_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic [7:0]    cpu_rdata,
  output logic          cpu_ack,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [7:0]    vid_rdata,
  output logic          vid_ack,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_wdata,
  output logic [7:0]    dma_rdata,
  output logic          dma_ack,
  output logic [AW-1:0] SRAM_ADDR,
  output logic [7:0]    SRAM_DATA_O,
  input  logic [7:0]    SRAM_DATA_I,
  output logic          SRAM_DATA_OE,
  output logic          SRAM_WE_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_DONE
  } state_e;

  localparam logic [1:0] P_CPU = 2'd0;
  localparam logic [1:0] P_VID = 2'd1;
  localparam logic [1:0] P_DMA = 2'd2;

  // The counter is loaded with N-1 so that the state is held for N cycles.
  localparam logic [2:0] RD_LOAD = 3'(RD_WAIT - 1);
  localparam logic [2:0] WE_LOAD = 3'(WE_WIDTH - 1);

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            rr_q, rr_d;          // 0 = cpu wins a cpu/dma tie, 1 = dma wins
  logic [1:0]      port_q, port_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      cpu_rdata_q, cpu_rdata_d;
  logic [7:0]      vid_rdata_q, vid_rdata_d;
  logic [7:0]      dma_rdata_q, dma_rdata_d;
  logic            oe_q, oe_d;
  logic            we_n_q, we_n_d;
  logic            cpu_ack_q, cpu_ack_d;
  logic            vid_ack_q, vid_ack_d;
  logic            dma_ack_q, dma_ack_d;

  // State register
  always_ff @(posedge clk_chipset or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      rr_q        <= 1'b0;
      port_q      <= P_CPU;
      addr_q      <= '0;
      wdata_q     <= 8'h00;
      cpu_rdata_q <= 8'h00;
      vid_rdata_q <= 8'h00;
      dma_rdata_q <= 8'h00;
      oe_q        <= 1'b0;
      we_n_q      <= 1'b1;
      cpu_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      port_q      <= port_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      oe_q        <= oe_d;
      we_n_q      <= we_n_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_ack_q   <= vid_ack_d;
      dma_ack_q   <= dma_ack_d;
    end
  end

  // Next-state logic: arbitration, sequencing, read-data capture.
  // Address and write data are only loaded in IDLE, so they cannot move
  // while WE_n is low.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    port_d      = port_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;
    dma_rdata_d = dma_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (vid_req) begin
          port_d  = P_VID;
          addr_d  = vid_addr;
          cnt_d   = RD_LOAD;
          state_d = S_RD;
        end else if (cpu_req && (!dma_req || !rr_q)) begin
          port_d  = P_CPU;
          addr_d  = cpu_addr;
          rr_d    = 1'b1;
          cnt_d   = RD_LOAD;
          if (cpu_we) begin
            wdata_d = cpu_wdata;
            state_d = S_WR_SETUP;
          end else begin
            state_d = S_RD;
          end
        end else if (dma_req) begin
          port_d  = P_DMA;
          addr_d  = dma_addr;
          rr_d    = 1'b0;
          cnt_d   = RD_LOAD;
          if (dma_we) begin
            wdata_d = dma_wdata;
            state_d = S_WR_SETUP;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (cnt_q == 3'd0) begin
          case (port_q)
            P_VID:   vid_rdata_d = SRAM_DATA_I;
            P_DMA:   dma_rdata_d = SRAM_DATA_I;
            default: cpu_rdata_d = SRAM_DATA_I;
          endcase
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_WR_SETUP: begin
        cnt_d   = WE_LOAD;
        state_d = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        if (cnt_q == 3'd0) begin
          state_d = S_WR_HOLD;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_WR_HOLD: state_d = S_IDLE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output logic: pin controls and acks are decoded from the next state so
  // that they come straight out of flops in the cycle of that state.
  always_comb begin
    logic ack_any;
    ack_any   = (state_d == S_DONE) || (state_d == S_WR_HOLD);
    oe_d      = (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE) ||
                (state_d == S_WR_HOLD);
    we_n_d    = (state_d != S_WR_PULSE);
    cpu_ack_d = ack_any && (port_d == P_CPU);
    vid_ack_d = ack_any && (port_d == P_VID);
    dma_ack_d = ack_any && (port_d == P_DMA);
  end

  assign cpu_rdata    = cpu_rdata_q;
  assign vid_rdata    = vid_rdata_q;
  assign dma_rdata    = dma_rdata_q;
  assign cpu_ack      = cpu_ack_q;
  assign vid_ack      = vid_ack_q;
  assign dma_ack      = dma_ack_q;
  assign SRAM_ADDR    = addr_q;
  assign SRAM_DATA_O  = wdata_q;
  assign SRAM_DATA_OE = oe_q;
  assign SRAM_WE_n    = we_n_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//   Bench for sram_arbiter: one default-timing instance driven through a
//   scoreboard, plus an instance with RD_WAIT=4 / WE_WIDTH=3 for the
//   stretched-timing sequence. Each instance has a small SRAM model.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we, vid_req, dma_req, dma_we;
  logic [20:0] cpu_addr, vid_addr, dma_addr;
  logic [7:0]  cpu_wdata, dma_wdata;
  logic [7:0]  cpu_rdata, vid_rdata, dma_rdata;
  logic        cpu_ack, vid_ack, dma_ack;
  logic [20:0] sram_addr;
  logic [7:0]  sram_do, sram_di;
  logic        sram_oe, sram_we_n;

  logic        b_cpu_req, b_cpu_we, b_vid_req, b_dma_req, b_dma_we;
  logic [20:0] b_cpu_addr, b_vid_addr, b_dma_addr;
  logic [7:0]  b_cpu_wdata, b_dma_wdata;
  logic [7:0]  b_cpu_rdata, b_vid_rdata, b_dma_rdata;
  logic        b_cpu_ack, b_vid_ack, b_dma_ack;
  logic [20:0] b_sram_addr;
  logic [7:0]  b_sram_do, b_sram_di;
  logic        b_sram_oe, b_sram_we_n;

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk_chipset(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .SRAM_ADDR(sram_addr), .SRAM_DATA_O(sram_do), .SRAM_DATA_I(sram_di),
    .SRAM_DATA_OE(sram_oe), .SRAM_WE_n(sram_we_n)
  );

  sram_arbiter #(.AW(21), .RD_WAIT(4), .WE_WIDTH(3)) dut_b (
    .clk_chipset(clk), .reset_n(reset_n),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_rdata(b_cpu_rdata), .cpu_ack(b_cpu_ack),
    .vid_req(b_vid_req), .vid_addr(b_vid_addr), .vid_rdata(b_vid_rdata), .vid_ack(b_vid_ack),
    .dma_req(b_dma_req), .dma_we(b_dma_we), .dma_addr(b_dma_addr), .dma_wdata(b_dma_wdata),
    .dma_rdata(b_dma_rdata), .dma_ack(b_dma_ack),
    .SRAM_ADDR(b_sram_addr), .SRAM_DATA_O(b_sram_do), .SRAM_DATA_I(b_sram_di),
    .SRAM_DATA_OE(b_sram_oe), .SRAM_WE_n(b_sram_we_n)
  );

  // SRAM models: 256 bytes indexed by the low address byte, written on any
  // clock edge where WE_n is low.
  logic [7:0] mem [256];
  logic [7:0] b_mem [256];
  assign sram_di   = mem[sram_addr[7:0]];
  assign b_sram_di = b_mem[b_sram_addr[7:0]];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]   = 8'(i) ^ 8'hA5;
      b_mem[i] = 8'(i) ^ 8'h3C;
    end
    forever begin
      @(posedge clk);
      if (!sram_we_n)   mem[sram_addr[7:0]]     = sram_do;
      if (!b_sram_we_n) b_mem[b_sram_addr[7:0]] = b_sram_do;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         port;   // 0 cpu, 1 vid, 2 dma
    bit         rd;
    logic [7:0] rdata;
    int         cyc;
  } sb_t;
  sb_t sbq[$];
  logic [7:0] last_rd [3];

  task automatic push(input int p, input bit rd, input logic [7:0] d, input int c);
    sb_t e;
    e.port = p; e.rd = rd; e.rdata = d; e.cyc = c;
    sbq.push_back(e);
  endtask

  function automatic logic [7:0] get_rdata(input int p);
    case (p)
      1:       return vid_rdata;
      2:       return dma_rdata;
      default: return cpu_rdata;
    endcase
  endfunction

  // Scoreboard: every ack pops the oldest expected completion.
  always @(negedge clk) begin
    int  nack;
    int  p;
    sb_t e;
    nack = int'(cpu_ack) + int'(vid_ack) + int'(dma_ack);
    if (nack != 0) begin
      chk("ack_onehot", nack, 1);
      p = cpu_ack ? 0 : (vid_ack ? 1 : 2);
      chk("ack_expected", int'(sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("ack_port", p, e.port);
        chk("ack_cycle", cyc, e.cyc);
        if (e.rd) begin
          chk("rdata", get_rdata(e.port), e.rdata);
          last_rd[e.port] = e.rdata;
        end else begin
          chk("wr_keeps_rdata", get_rdata(e.port), last_rd[e.port]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cpu_xfer(input logic we, input logic [20:0] a, input logic [7:0] d);
    int n = 0;
    cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    do begin @(negedge clk); n++; end while (!cpu_ack && n < 40);
    if (!cpu_ack) chk("cpu_ack_timeout", 0, 1);
    tick(); cpu_req = 1'b0;
  endtask

  task automatic vid_xfer(input logic [20:0] a);
    int n = 0;
    vid_addr = a; vid_req = 1'b1;
    do begin @(negedge clk); n++; end while (!vid_ack && n < 40);
    if (!vid_ack) chk("vid_ack_timeout", 0, 1);
    tick(); vid_req = 1'b0;
  endtask

  task automatic dma_xfer(input logic we, input logic [20:0] a, input logic [7:0] d);
    int n = 0;
    dma_we = we; dma_addr = a; dma_wdata = d; dma_req = 1'b1;
    do begin @(negedge clk); n++; end while (!dma_ack && n < 40);
    if (!dma_ack) chk("dma_ack_timeout", 0, 1);
    tick(); dma_req = 1'b0;
  endtask

  task automatic do_reset();
    tick(); reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) last_rd[i] = 8'h00;
    tick();
  endtask

  typedef struct {
    int          port;
    bit          we;
    logic [20:0] addr;
    logic [7:0]  wd;
  } vec_t;
  vec_t vt [9];

  initial begin
    int base;
    vt[0] = '{2, 1'b1, 21'h00010,  8'h3C};
    vt[1] = '{2, 1'b0, 21'h00010,  8'h00};
    vt[2] = '{1, 1'b0, 21'h00010,  8'h00};
    vt[3] = '{0, 1'b1, 21'h1FFFFF, 8'hFF};
    vt[4] = '{0, 1'b0, 21'h1FFFFF, 8'h00};
    vt[5] = '{2, 1'b0, 21'h000CD,  8'h00};
    vt[6] = '{1, 1'b0, 21'h00042,  8'h00};
    vt[7] = '{0, 1'b1, 21'h00000,  8'h00};
    vt[8] = '{0, 1'b0, 21'h00000,  8'h00};

    reset_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    vid_req = 0; vid_addr = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = '0; b_cpu_wdata = '0;
    b_vid_req = 0; b_vid_addr = '0;
    b_dma_req = 0; b_dma_we = 0; b_dma_addr = '0; b_dma_wdata = '0;
    for (int i = 0; i < 3; i++) last_rd[i] = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_vid_ack", vid_ack, 0);
    chk("rst_dma_ack", dma_ack, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_vid_rdata", vid_rdata, 0);
    chk("rst_dma_rdata", dma_rdata, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_data_o", sram_do, 0);
    chk("rst_oe", sram_oe, 0);
    chk("rst_we_n", sram_we_n, 1);
    chk("b_rst_oe", b_sram_oe, 0);
    chk("b_rst_we_n", b_sram_we_n, 1);
    chk("b_rst_ack", b_cpu_ack, 0);
    reset_n = 1'b1;
    tick();

    // CPU write with pin checks
    base = cyc;
    push(0, 1'b0, 8'h00, base + 3);
    fork
      cpu_xfer(1'b1, 21'h1ABCD, 8'h5A);
      for (int k = 0; k <= 4; k++) begin
        @(negedge clk);
        chk($sformatf("wr_oe_c%0d", k), sram_oe, (k >= 1 && k <= 3));
        chk($sformatf("wr_we_n_c%0d", k), sram_we_n, (k != 2));
        if (k >= 1 && k <= 3) begin
          chk($sformatf("wr_addr_c%0d", k), sram_addr, 21'h1ABCD);
          chk($sformatf("wr_data_c%0d", k), sram_do, 8'h5A);
        end
      end
    join
    tick();
    chk("mem_written", mem[8'hCD], 8'h5A);

    // CPU read back, OE low throughout
    base = cyc;
    push(0, 1'b1, 8'h5A, base + 3);
    fork
      cpu_xfer(1'b0, 21'h1ABCD, 8'h00);
      for (int k = 0; k <= 4; k++) begin
        @(negedge clk);
        chk($sformatf("rd_oe_c%0d", k), sram_oe, 0);
        chk($sformatf("rd_we_n_c%0d", k), sram_we_n, 1);
      end
    join
    tick();

    // Table of single transactions on all ports
    foreach (vt[i]) begin
      base = cyc;
      push(vt[i].port, !vt[i].we, vt[i].we ? 8'h00 : mem[vt[i].addr[7:0]], base + 3);
      case (vt[i].port)
        1:       vid_xfer(vt[i].addr);
        2:       dma_xfer(vt[i].we, vt[i].addr, vt[i].wd);
        default: cpu_xfer(vt[i].we, vt[i].addr, vt[i].wd);
      endcase
    end

    // All three ports request reads in the same cycle
    do_reset();
    base = cyc;
    push(1, 1'b1, mem[8'h60], base + 3);
    push(0, 1'b1, mem[8'h61], base + 7);
    push(2, 1'b1, mem[8'h62], base + 11);
    fork
      vid_xfer(21'h00360);
      cpu_xfer(1'b0, 21'h00361, 8'h00);
      dma_xfer(1'b0, 21'h00362, 8'h00);
    join

    // cpu and dma both hold req for 8 accesses: strict alternation from cpu
    do_reset();
    base = cyc;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) push(0, 1'b1, mem[8'(i / 2)], base + 3 + 4 * i);
      else            push(2, 1'b1, mem[8'(8 + i / 2)], base + 3 + 4 * i);
    end
    fork
      for (int j = 0; j < 4; j++) cpu_xfer(1'b0, 21'h00100 + 21'(j), 8'h00);
      for (int j = 0; j < 4; j++) dma_xfer(1'b0, 21'h00208 + 21'(j), 8'h00);
    join

    // Reset during WR_PULSE aborts the write; the held request is re-granted
    tick();
    base = cyc;
    push(0, 1'b0, 8'h00, base + 6);
    fork
      cpu_xfer(1'b1, 21'h00055, 8'hE7);
      begin
        repeat (3) @(negedge clk);
        chk("abort_in_pulse", sram_we_n, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_we_n", sram_we_n, 1);
        chk("abort_oe", sram_oe, 0);
        chk("abort_ack", cpu_ack, 0);
        chk("abort_rdata_vid", vid_rdata, 0);
        chk("abort_rdata_dma", dma_rdata, 0);
        for (int i = 0; i < 3; i++) last_rd[i] = 8'h00;
        @(negedge clk);
        chk("abort_no_write", mem[8'h55], 8'h55 ^ 8'hA5);
        reset_n = 1'b1;
      end
    join
    base = cyc;
    push(0, 1'b1, 8'hE7, base + 3);
    cpu_xfer(1'b0, 21'h00055, 8'h00);

    // Stretched timing instance: write then read
    tick();
    b_cpu_we = 1'b1; b_cpu_addr = 21'h0ABCD; b_cpu_wdata = 8'hC3; b_cpu_req = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("b_wr_oe_c%0d", k), b_sram_oe, (k >= 1 && k <= 5));
      chk($sformatf("b_wr_we_n_c%0d", k), b_sram_we_n, !(k >= 2 && k <= 4));
      chk($sformatf("b_wr_ack_c%0d", k), b_cpu_ack, (k == 5));
      if (!b_sram_we_n) begin
        chk($sformatf("b_wr_addr_c%0d", k), b_sram_addr, 21'h0ABCD);
        chk($sformatf("b_wr_data_c%0d", k), b_sram_do, 8'hC3);
      end
      if (k == 5) begin tick(); b_cpu_req = 1'b0; end
    end
    tick();
    b_cpu_we = 1'b0; b_cpu_req = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("b_rd_oe_c%0d", k), b_sram_oe, 0);
      chk($sformatf("b_rd_ack_c%0d", k), b_cpu_ack, (k == 5));
      if (k == 5) begin
        chk("b_rd_data", b_cpu_rdata, 8'hC3);
        tick(); b_cpu_req = 1'b0;
      end
    end

    tick();
    chk("sb_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
